// File: rtl/vmem_pkg.sv
// Shared types for the vector-capable data-memory responder.
// State encoding, burst length and request decode.
package vmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } vmem_state_e;

  localparam logic [1:0] BEATS_LAST = 2'd3;

  typedef enum logic [2:0] {
    REQ_NONE,
    REQ_RD,
    REQ_WR,
    REQ_RD_BURST,
    REQ_WR_BURST
  } vmem_req_e;

  // A write always wins over a simultaneous read.
  function automatic vmem_req_e decode_req(
    input logic rd,
    input logic wr,
    input logic burst
  );
    vmem_req_e r;
    r = REQ_NONE;
    unique case (1'b1)
      wr && burst:           r = REQ_WR_BURST;
      wr && !burst:          r = REQ_WR;
      !wr && rd && burst:    r = REQ_RD_BURST;
      !wr && rd && !burst:   r = REQ_RD;
      default:               r = REQ_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vmem_responder_if.sv
// Data-memory bus between the datapath and the responder.
// Master is the initiator, slave is the memory side.
interface vmem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic              MemRead;
  logic              wren;
  logic              burst;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] q;
  logic              q_valid;
  logic [1:0]        beat;
  logic              busy;
  logic              done;

  modport master (
    output MemRead,
    output wren,
    output burst,
    output address,
    output data,
    input  q,
    input  q_valid,
    input  beat,
    input  busy,
    input  done
  );

  modport slave (
    input  MemRead,
    input  wren,
    input  burst,
    input  address,
    input  data,
    output q,
    output q_valid,
    output beat,
    output busy,
    output done
  );

endinterface

// File: rtl/mem_array_1rw.sv
// Single-port synchronous array with registered read.
// Read register resets; array contents do not.
module mem_array_1rw #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) begin
      rdata_d = mem[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/vmem_responder.sv
// Memory-side responder: scalar byte access plus 4-beat
// vector bursts, sequenced by a small FSM over one array.
module vmem_responder
  import vmem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int BEATS  = 4
) (
  input  logic           clock,
  input  logic           reset,
  vmem_responder_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(BEATS);

  vmem_state_e       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        beat_q, beat_d;
  logic              q_valid_q, q_valid_d;
  logic              done_q, done_d;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  vmem_req_e         req;

  assign req = decode_req(bus.MemRead, bus.wren, bus.burst);

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    beat_d    = beat_q;
    q_valid_d = 1'b0;
    done_d    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = base_q + ADDR_W'(cnt_q);
    unique case (state_q)
      ST_IDLE: begin
        mem_addr = bus.address;
        unique case (req)
          REQ_RD: begin
            mem_en    = 1'b1;
            q_valid_d = 1'b1;
            beat_d    = 2'd0;
            done_d    = 1'b1;
          end
          REQ_WR: begin
            mem_en = 1'b1;
            mem_we = 1'b1;
            beat_d = 2'd0;
            done_d = 1'b1;
          end
          REQ_RD_BURST: begin
            mem_en    = 1'b1;
            q_valid_d = 1'b1;
            beat_d    = 2'd0;
            base_d    = bus.address;
            cnt_d     = CNT_W'(1);
            state_d   = ST_RD;
          end
          REQ_WR_BURST: begin
            mem_en  = 1'b1;
            mem_we  = 1'b1;
            beat_d  = 2'd0;
            base_d  = bus.address;
            cnt_d   = CNT_W'(1);
            state_d = ST_WR;
          end
          default: ;
        endcase
      end
      ST_RD: begin
        mem_en    = 1'b1;
        q_valid_d = 1'b1;
        beat_d    = cnt_q;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == BEATS_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_WR: begin
        mem_en = 1'b1;
        mem_we = 1'b1;
        beat_d = cnt_q;
        cnt_d  = cnt_q + CNT_W'(1);
        // done lands alongside beat=3, the cycle after it commits
        if (cnt_q == BEATS_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      cnt_q     <= '0;
      beat_q    <= '0;
      q_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      cnt_q     <= cnt_d;
      beat_q    <= beat_d;
      q_valid_q <= q_valid_d;
      done_q    <= done_d;
    end
  end

  mem_array_1rw #(
    .AW (ADDR_W),
    .DW (DATA_W)
  ) u_mem (
    .clk   (clock),
    .rst_n (reset),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (bus.data),
    .rdata (mem_rdata)
  );

  assign bus.q       = mem_rdata;
  assign bus.q_valid = q_valid_q;
  assign bus.beat    = beat_q;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = done_q;

endmodule

// File: doc/vmem_responder.md
Name: vmem_responder

Overview:
- Memory-side responder for the processor's 8-bit data-memory bus (MemRead / wren / address / data / q).
- Serves scalar byte reads and writes for the scalar datapath.
- Serves 4-beat burst reads and writes for the vector extension's load and store, which move a 32-bit vector as four consecutive bytes, MSB byte first.
- Owns the storage array and the burst sequencing FSM, replacing the plain synchronous memory macro.

Parameters:
- ADDR_W, 8, address width; the array holds 2^ADDR_W words.
- DATA_W, 8, word width.
- BEATS, 4, burst length; fixed at 4 and must match the vector width (4 x 8 bits).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemRead  in  1  read request; sampled only while busy=0.
- wren  in  1  write request; sampled only while busy=0.
- burst  in  1  qualifies a request as a 4-beat burst; sampled with the request.
- address  in  ADDR_W  start address of the request.
- data  in  DATA_W  write data. Beat 0 is presented in the accept cycle; beat k is presented k cycles later.
- q  out  DATA_W  read data, registered.
- q_valid  out  1  high for exactly the cycles in which q carries a newly read word.
- beat  out  2  beat index of the current q, or of the write beat being committed.
- busy  out  1  combinational; high while the FSM is not in IDLE.
- done  out  1  one-cycle pulse marking completion of any request.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, q=0, q_valid=0, beat=0, done=0, internal counter=0.
  - Array contents are NOT cleared.
- Request accept: a request is accepted at the rising edge ending any cycle with busy=0 and (MemRead|wren)=1.
  - If MemRead=wren=1, the write wins and the read is dropped.
  - Requests presented while busy=1 are ignored. The initiator must hold its controls, or re-present them after done.
- FSM states: IDLE, RD_BURST, WR_BURST.
- IDLE, scalar read (burst=0):
  - q <= mem[address]; q_valid=1, beat=0, done=1 in the next cycle.
  - Latency 1 cycle. State stays IDLE.
- IDLE, scalar write (burst=0):
  - mem[address] <= data at the accept edge; done=1 in the next cycle.
  - q is unchanged; q_valid=0.
- IDLE, burst read:
  - Latch base=address.
  - q <= mem[base]; beat=0, q_valid=1; counter=1; go to RD_BURST.
- RD_BURST, each edge:
  - q <= mem[base+counter]; beat=counter, q_valid=1; counter increments.
  - When counter==3 at the edge, go to IDLE; done=1 in the same cycle as beat 3.
  - Total: 4 consecutive q_valid cycles; busy high for 3 cycles.
- IDLE, burst write:
  - mem[base] <= data at the accept edge; counter=1; go to WR_BURST.
- WR_BURST, each edge:
  - mem[base+counter] <= data; counter increments.
  - After beat 3 is written, go to IDLE; done pulses the cycle after beat 3 commits.
  - beat reflects the index committed at the previous edge.
- Address arithmetic is modulo 2^ADDR_W. For example, base=8'hFE gives 8'hFE, 8'hFF, 8'h00, 8'h01.
- Output hold rules:
  - q holds its last value whenever q_valid=0.
  - done and q_valid are deasserted in every cycle not listed above.
- Reset asserted mid-burst:
  - Immediate return to IDLE with all outputs at reset values.
  - Bytes already committed by a write burst remain in the array; the remaining beats are never written.
- No read-during-write hazard exists, because only one operation is active at a time.

Decomposition:
- Shared package `vmem_pkg`:
  - state encoding constants ST_IDLE=2'd0, ST_RD=2'd1, ST_WR=2'd2;
  - BEATS_LAST=2'd3.
- One sub-module: `mem_array_1rw`, a single-port synchronous array of 2^ADDR_W x DATA_W with a registered read and a write enable. The FSM, counter and base register stay in vmem_responder.

Test Plan:
- Reset, then a scalar write: address=8'h10, data=8'h5A, wren=1 for one cycle. Then a scalar read of 8'h10 -> q=8'h5A with q_valid=1 and done=1 exactly one cycle after accept.
- Preload 8'h20..8'h23 with 8'h11, 8'h22, 8'h33, 8'h44. Burst read at 8'h20 -> q=8'h11, 8'h22, 8'h33, 8'h44 on 4 consecutive cycles, beat=0..3, busy=1 for 3 cycles, done coincident with beat 3.
- Burst write at 8'hFE with data sequence 8'hA0, 8'hA1, 8'hA2, 8'hA3. Scalar reads then return 8'hFE=A0, 8'hFF=A1, 8'h00=A2, 8'h01=A3 (wrap-around).
- MemRead=wren=1 at 8'h30 with data=8'h77 -> write performed, q_valid stays 0, and a later read of 8'h30 returns 8'h77. A request presented while busy=1 -> ignored, with no array change.
- Burst write at 8'h40 (old contents 8'h00) with data 8'hB0..8'hB3; assert reset after beat 1 commits -> outputs return to 0 immediately. Afterwards 8'h40=B0, 8'h41=B1, and 8'h42 and 8'h43 are still 8'h00.
